mem_port_arbiter: RTL and testbench

- Sits directly upstream of the unified single-port instruction/data memory. Builds that memory's 61-bit request bus and splits its 64-bit response.
- Arbitrates each cycle between the IF stage (instruction fetch) and the MEM stage (load/store).
- Registers the fetched instruction toward IF/ID and raises stalls so the pipeline resolves the structural hazard.
- Provides a starvation guard and access counters.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter in front of the unified single-port memory
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int MAX_DATA_RUN = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [2:0]        ex_mem_fun3,
    input  logic [31:0]       ex_mem_wdata,
    output logic [60:0]       mem_in,
    input  logic [63:0]       mem_out,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  data_cnt
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_DATA_RUN - 1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    typedef enum logic {
        GRANT_DATA_OK,
        FORCE_FETCH
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic             stall_mem_q;

    logic        data_req;
    logic        data_grant;
    logic        fetch_grant;
    logic        eff_read;
    logic        bad_align;
    logic        bad_fun3;
    logic        req_err;
    logic [11:0] pc12;
    logic [11:0] addr12;

    assign pc12   = 12'(if_pc);
    assign addr12 = 12'(ex_mem_addr);

    // Grant decision: data normally wins, a pending fetch wins only in the forced slot
    assign data_req    = ex_mem_read | ex_mem_write;
    assign data_grant  = data_req & ~((state == FORCE_FETCH) & if_req);
    assign fetch_grant = if_req & ~data_grant;

    // A simultaneous read+write is issued as a store only
    assign eff_read   = ex_mem_read & ~ex_mem_write;
    assign load_valid = data_grant & eff_read;
    assign load_data  = mem_out[63:32];
    assign stall_if   = if_req & ~fetch_grant;
    assign stall_mem  = data_req & ~data_grant;

    // Alignment and funct3 legality of the data request
    always_comb begin
        bad_align = 1'b0;
        bad_fun3  = 1'b0;
        if ((ex_mem_fun3 == 3'b001 || ex_mem_fun3 == 3'b101) && ex_mem_addr[0])
            bad_align = 1'b1;
        if (ex_mem_fun3 == 3'b010 && ex_mem_addr[1:0] != 2'b00)
            bad_align = 1'b1;
        if (ex_mem_write)
            bad_fun3 = !(ex_mem_fun3 inside {3'b000, 3'b001, 3'b010});
        else
            bad_fun3 = ex_mem_fun3 inside {3'b011, 3'b110, 3'b111};
    end

    // A request stalled last cycle is the same access retried; it was already flagged
    assign req_err = data_req & (bad_align | bad_fun3) & ~stall_mem_q;

    // Memory request bus: data access, instruction fetch, or idle zeros
    always_comb begin
        mem_in = '0;
        if (data_grant)
            mem_in = {eff_read, ex_mem_write, pc12, addr12, ex_mem_fun3, ex_mem_wdata};
        else if (fetch_grant)
            mem_in = {2'b00, pc12, 47'd0};
    end

    // Arbitration FSM, starvation run counter, fetch register, error pulse and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= GRANT_DATA_OK;
            run_cnt      <= '0;
            stall_mem_q  <= 1'b0;
            inst         <= NOP;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
            data_cnt     <= '0;
        end else begin
            case (state)
                GRANT_DATA_OK:
                    if (data_grant && if_req && run_cnt >= RUN_LAST)
                        state <= FORCE_FETCH;
                FORCE_FETCH:
                    state <= GRANT_DATA_OK;
                default:
                    state <= GRANT_DATA_OK;
            endcase

            if (fetch_grant || !if_req)
                run_cnt <= '0;
            else if (data_grant && run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 1'b1;

            stall_mem_q  <= stall_mem;
            misalign_err <= req_err;

            inst_valid <= fetch_grant;
            if (fetch_grant) begin
                inst      <= mem_out[31:0];
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (data_grant)
                data_cnt <= data_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [11:0] if_pc;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [11:0] ex_mem_addr;
    logic [2:0]  ex_mem_fun3;
    logic [31:0] ex_mem_wdata;
    logic [60:0] mem_in;
    logic [63:0] mem_out;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        misalign_err;
    logic [3:0]  fetch_cnt;
    logic [3:0]  data_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(12), .MAX_DATA_RUN(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_pc(if_pc),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_addr(ex_mem_addr), .ex_mem_fun3(ex_mem_fun3),
        .ex_mem_wdata(ex_mem_wdata), .mem_in(mem_in), .mem_out(mem_out),
        .inst(inst), .inst_valid(inst_valid), .load_data(load_data),
        .load_valid(load_valid), .stall_if(stall_if), .stall_mem(stall_mem),
        .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .data_cnt(data_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [11:0] pc;
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [63:0] mo;
        logic [60:0] e_bus;
        logic        e_lv;
        logic [31:0] e_ld;
        logic        e_si;
        logic        e_sm;
        logic [31:0] e_inst;
        logic        e_iv;
        logic        e_err;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [11:0] pc, input logic rd, input logic wr,
                         input logic [11:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                         input logic [63:0] mo);
        if_req = ir; if_pc = pc; ex_mem_read = rd; ex_mem_write = wr;
        ex_mem_addr = addr; ex_mem_fun3 = f3; ex_mem_wdata = wd; mem_out = mo;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(0, 12'h0, 0, 0, 12'h0, 3'b0, 32'h0, 64'h0);
        @(posedge clk);
        #1;
        chk("idle_iv", 64'(inst_valid), 64'd0);
        chk("idle_err", 64'(misalign_err), 64'd0);
    endtask

    initial begin
        // if_req pc rd wr addr f3 wdata mem_out | bus lv ld si sm inst iv err
        vt[0]  = '{1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 3'b000, 32'h0, {32'h0, 32'h00300493},
                   {2'b00, 12'h004, 12'h000, 3'b000, 32'h0}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00300493, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 12'h008, 1'b1, 1'b0, 12'h001, 3'b001, 32'h0, {32'h00000211, 32'h11111111},
                   {2'b10, 12'h008, 12'h001, 3'b001, 32'h0}, 1'b1, 32'h211, 1'b1, 1'b0, 32'h00300493, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h00A, 3'b000, 32'hFF, 64'h0,
                   {2'b01, 12'h000, 12'h00A, 3'b000, 32'hFF}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 3'b011, 32'h12345678, 64'h0,
                   {2'b01, 12'h000, 12'h000, 3'b011, 32'h12345678}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 3'b010, 32'h0, {32'hCAFEBABE, 32'h0},
                   {2'b10, 12'h000, 12'h002, 3'b010, 32'h0}, 1'b1, 32'hCAFEBABE, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h004, 3'b010, 32'h0, {32'h01234567, 32'h0},
                   {2'b10, 12'h000, 12'h004, 3'b010, 32'h0}, 1'b1, 32'h01234567, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 3'b110, 32'h0, {32'h00000055, 32'h0},
                   {2'b10, 12'h000, 12'h000, 3'b110, 32'h0}, 1'b1, 32'h55, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 3'b010, 32'hA5A5A5A5, {32'h00000077, 32'h0},
                   {2'b01, 12'h000, 12'h010, 3'b010, 32'hA5A5A5A5}, 1'b0, 32'h77, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h003, 3'b101, 32'h0, {32'h00000088, 32'h0},
                   {2'b10, 12'h000, 12'h003, 3'b101, 32'h0}, 1'b1, 32'h88, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 3'b000, 32'h0, {32'h00000099, 32'h0},
                   61'h0, 1'b0, 32'h99, 1'b0, 1'b0, 32'h00300493, 1'b0, 1'b0};
        vt[10] = '{1'b1, 12'hFFC, 1'b0, 1'b0, 12'h000, 3'b000, 32'h0, {32'h0, 32'h0000006F},
                   {2'b00, 12'hFFC, 12'h000, 3'b000, 32'h0}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000006F, 1'b1, 1'b0};
        vt[11] = '{1'b1, 12'h010, 1'b0, 1'b1, 12'h020, 3'b001, 32'h1234, 64'h0,
                   {2'b01, 12'h010, 12'h020, 3'b001, 32'h1234}, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000006F, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 12'h0, 0, 0, 12'h0, 3'b0, 32'h0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", 64'(inst), 64'h13);
        chk("rst_iv", 64'(inst_valid), 64'd0);
        chk("rst_fcnt", 64'(fetch_cnt), 64'd0);
        chk("rst_dcnt", 64'(data_cnt), 64'd0);
        chk("rst_bus", 64'(mem_in), 64'd0);
        chk("rst_err", 64'(misalign_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors, each followed by an idle cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vt[i].if_req, vt[i].pc, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].f3, vt[i].wd, vt[i].mo);
            #1;
            chk($sformatf("v%0d_bus", i), 64'(mem_in), 64'(vt[i].e_bus));
            chk($sformatf("v%0d_lv", i), 64'(load_valid), 64'(vt[i].e_lv));
            chk($sformatf("v%0d_ld", i), 64'(load_data), 64'(vt[i].e_ld));
            chk($sformatf("v%0d_si", i), 64'(stall_if), 64'(vt[i].e_si));
            chk($sformatf("v%0d_sm", i), 64'(stall_mem), 64'(vt[i].e_sm));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_inst", i), 64'(inst), 64'(vt[i].e_inst));
            chk($sformatf("v%0d_iv", i), 64'(inst_valid), 64'(vt[i].e_iv));
            chk($sformatf("v%0d_err", i), 64'(misalign_err), 64'(vt[i].e_err));
            idle_cycle();
        end
        chk("tbl_fcnt", 64'(fetch_cnt), 64'd2);
        chk("tbl_dcnt", 64'(data_cnt), 64'd9);

        // Starvation guard: four data grants, one forced fetch, then data again
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1, 12'h020, 1, 0, 12'h100, 3'b010, 32'h0, {32'hBEEF0000 + 32'(c), 32'h00A00093});
            #1;
            chk($sformatf("starve%0d_sm", c), 64'(stall_mem), 64'(c == 4));
            chk($sformatf("starve%0d_si", c), 64'(stall_if), 64'(c != 4));
            chk($sformatf("starve%0d_rd", c), 64'(mem_in[60:59]), (c == 4) ? 64'd0 : 64'd2);
            chk($sformatf("starve%0d_lv", c), 64'(load_valid), 64'(c != 4));
            if (c == 4)
                chk("starve4_pc", 64'(mem_in[58:47]), 64'h020);
            @(posedge clk);
            #1;
            chk($sformatf("starve%0d_iv", c), 64'(inst_valid), 64'(c == 4));
            chk($sformatf("starve%0d_err", c), 64'(misalign_err), 64'd0);
        end
        chk("starve_inst", 64'(inst), 64'h00A00093);
        idle_cycle();
        chk("starve_fcnt", 64'(fetch_cnt), 64'd3);
        chk("starve_dcnt", 64'(data_cnt), 64'd14);

        // Reset asserted while the FSM is in its forced-fetch slot
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1, 12'h040, 1, 0, 12'h200, 3'b010, 32'h0, {32'h0, 32'h12345013});
        end
        @(negedge clk);
        chk("force_sm", 64'(stall_mem), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inst", 64'(inst), 64'h13);
        chk("mid_rst_iv", 64'(inst_valid), 64'd0);
        chk("mid_rst_fcnt", 64'(fetch_cnt), 64'd0);
        chk("mid_rst_dcnt", 64'(data_cnt), 64'd0);
        chk("mid_rst_sm", 64'(stall_mem), 64'd0);
        chk("mid_rst_si", 64'(stall_if), 64'd1);
        drive(0, 12'h0, 0, 0, 12'h0, 3'b0, 32'h0, 64'h0);
        #1;
        chk("mid_rst_bus", 64'(mem_in), 64'd0);
        chk("mid_rst_si0", 64'(stall_if), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap at CNT_W=4
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1, 12'(i * 4), 0, 0, 12'h0, 3'b0, 32'h0, {32'h0, 32'(i)});
            @(posedge clk);
            #1;
            if (i == 14)
                chk("wrap_fcnt15", 64'(fetch_cnt), 64'd15);
        end
        chk("wrap_fcnt0", 64'(fetch_cnt), 64'd0);
        chk("wrap_inst", 64'(inst), 64'd15);
        chk("wrap_dcnt", 64'(data_cnt), 64'd0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
